// File: rtl/tx_bram_wr_ctrl.sv
`timescale 1ns / 1ps
// tx_bram_wr_ctrl: AXI-Stream to circular BRAM writer (port A) for the tx packet buffer.
// Writes accepted words into a 2**ADDR_WIDTH ring, commits whole packets to the reader
// via commit_ptr and a one-cycle descriptor, and rewinds on oversized packets.
// Optional build macro TX_BRAM_WR_STATS_EN adds saturating pkt_cnt / drop_cnt ports.
// MAX_PKT_WORDS must be below 2**ADDR_WIDTH so the length fits pkt_len.
module tx_bram_wr_ctrl #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned MAX_PKT_WORDS = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   input  logic [ADDR_WIDTH-1:0] rd_ptr,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic [ADDR_WIDTH-1:0] commit_ptr,
   output logic                  pkt_valid,
   output logic [ADDR_WIDTH-1:0] pkt_start,
   output logic [ADDR_WIDTH-1:0] pkt_len,
   output logic                  pkt_drop
`ifdef TX_BRAM_WR_STATS_EN
   ,
   output logic [15:0]           pkt_cnt,
   output logic [15:0]           drop_cnt
`endif
);

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StCommit,
      StDrop,
      StDropEnd
   } state_e;

   // One slot always stays empty, so "full" is used == depth-1 (all ones).
   localparam logic [ADDR_WIDTH-1:0] FullLvl = '1;
   localparam logic [ADDR_WIDTH-1:0] MaxLen  = ADDR_WIDTH'(MAX_PKT_WORDS);
   localparam logic [ADDR_WIDTH-1:0] One     = ADDR_WIDTH'(1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   start_ptr_q, start_ptr_d;
   logic [ADDR_WIDTH-1:0]   len_cnt_q, len_cnt_d;
   logic [ADDR_WIDTH-1:0]   commit_ptr_q, commit_ptr_d;
   logic                    ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
   logic [ADDR_WIDTH-1:0]   used;
   logic                    full;
   logic                    tready_c;
   logic                    accept;
   logic                    pkt_valid_c;
   logic                    pkt_drop_c;

   // Ring occupancy follows rd_ptr every cycle; modular subtraction handles the wrap.
   assign used = wr_ptr_q - rd_ptr;
   assign full = (used == FullLvl);

   // Ready depends only on state and occupancy, never on tvalid.
   always_comb begin
      tready_c = 1'b0;
      unique case (state_q)
         StIdle, StData: tready_c = ~full;
         StDrop:         tready_c = 1'b1;
         default:        tready_c = 1'b0;
      endcase
   end

   // Held low while reset is asserted so every output reads 0 during reset.
   assign s_axis_tready = tready_c & ~rst;
   assign accept        = s_axis_tvalid & s_axis_tready;

   // Next-state, pointer bookkeeping and registered RAM write request.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      start_ptr_d  = start_ptr_q;
      len_cnt_d    = len_cnt_q;
      commit_ptr_d = commit_ptr_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      pkt_valid_c  = 1'b0;
      pkt_drop_c   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               start_ptr_d = wr_ptr_q;
               len_cnt_d   = One;
               ram_we_d    = 1'b1;
               ram_addr_d  = wr_ptr_q;
               ram_din_d   = s_axis_tdata;
               wr_ptr_d    = wr_ptr_q + One;
               state_d     = s_axis_tlast ? StCommit : StData;
            end
         end
         StData: begin
            if (accept) begin
               if (len_cnt_q == MaxLen) begin
                  // Oversized: discard this word and rewind over the partial packet.
                  wr_ptr_d = start_ptr_q;
                  state_d  = s_axis_tlast ? StDropEnd : StDrop;
               end else begin
                  ram_we_d   = 1'b1;
                  ram_addr_d = wr_ptr_q;
                  ram_din_d  = s_axis_tdata;
                  wr_ptr_d   = wr_ptr_q + One;
                  len_cnt_d  = len_cnt_q + One;
                  if (s_axis_tlast) begin
                     state_d = StCommit;
                  end
               end
            end
         end
         StCommit: begin
            pkt_valid_c  = 1'b1;
            commit_ptr_d = wr_ptr_q;
            state_d      = StIdle;
         end
         StDrop: begin
            if (accept && s_axis_tlast) begin
               state_d = StDropEnd;
            end
         end
         StDropEnd: begin
            pkt_drop_c = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         start_ptr_q  <= '0;
         len_cnt_q    <= '0;
         commit_ptr_q <= '0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         start_ptr_q  <= start_ptr_d;
         len_cnt_q    <= len_cnt_d;
         commit_ptr_q <= commit_ptr_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
      end
   end

   assign ram_en     = ram_we_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_din    = ram_din_q;
   assign commit_ptr = commit_ptr_q;
   assign pkt_valid  = pkt_valid_c;
   assign pkt_drop   = pkt_drop_c;
   // Descriptor fields are zero outside the commit pulse.
   assign pkt_start  = pkt_valid_c ? start_ptr_q : '0;
   assign pkt_len    = pkt_valid_c ? len_cnt_q : '0;

`ifdef TX_BRAM_WR_STATS_EN
   // Saturating packet / drop counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (pkt_valid_c && (pkt_cnt != 16'hFFFF)) begin
            pkt_cnt <= pkt_cnt + 16'd1;
         end
         if (pkt_drop_c && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end
`else
   // Statistics counters not built.
`endif

endmodule
